// File: rtl/dct_pkg.sv
// dct_pkg: shared constants, zigzag table and read-state type for the DCT serializer path.
`default_nettype none

package dct_pkg;

  localparam int DATA_W = 12;
  localparam int BLK    = 8;

  // ZZ[k] is the raster address (row*8+col) of zigzag position k.
  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } rd_state_t;

endpackage

`default_nettype wire

// File: rtl/zz_bank.sv
// zz_bank: one 64-entry coefficient bank with an 8-lane row write port,
// a single asynchronous read port and a set/clear full flag.
`default_nettype none

module zz_bank #(
  parameter int DATA_W = dct_pkg::DATA_W
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             wr_en,
  input  logic [2:0]                       wr_row,
  input  logic [dct_pkg::BLK*DATA_W-1:0]   wr_data,
  input  logic [5:0]                       rd_addr,
  output logic [DATA_W-1:0]                rd_data,
  input  logic                             set_full,
  input  logic                             clr_full,
  output logic                             full
);
  import dct_pkg::*;

  logic [DATA_W-1:0] mem [64];

  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      for (int c = 0; c < BLK; c++) begin
        mem[{wr_row, 3'(c)}] <= wr_data[c*DATA_W +: DATA_W];
      end
    end
  end

  assign rd_data = mem[rd_addr];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      full <= 1'b0;
    end else if (set_full) begin
      full <= 1'b1;
    end else if (clr_full) begin
      full <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dct_zigzag_serializer.sv
// dct_zigzag_serializer: ping-pong buffers 8x8 coefficient blocks and streams them in JPEG zigzag order.
// Optional sticky o_overflow port enabled by defining DCT_ZZ_OVERFLOW_EN.
`default_nettype none

module dct_zigzag_serializer #(
  parameter int DATA_W = dct_pkg::DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data0,
  input  logic [DATA_W-1:0] i_data1,
  input  logic [DATA_W-1:0] i_data2,
  input  logic [DATA_W-1:0] i_data3,
  input  logic [DATA_W-1:0] i_data4,
  input  logic [DATA_W-1:0] i_data5,
  input  logic [DATA_W-1:0] i_data6,
  input  logic [DATA_W-1:0] i_data7,
  output logic              o_in_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [5:0]        o_index,
  output logic              o_last
`ifdef DCT_ZZ_OVERFLOW_EN
  ,
  output logic              o_overflow
`endif
);
  import dct_pkg::*;

  rd_state_t              state, state_nxt;
  logic                   wr_bank, rd_bank;
  logic [2:0]             row;
  logic [1:0]             full;
  logic [DATA_W-1:0]      bank_q [2];
  logic [BLK*DATA_W-1:0]  row_data;
  logic                   accept, row_done;
  logic                   load, load_bank, go_idle, clr_rd;
  logic [5:0]             load_k, rd_addr;

  assign row_data   = {i_data7, i_data6, i_data5, i_data4,
                       i_data3, i_data2, i_data1, i_data0};
  assign o_in_ready = !full[wr_bank];
  assign accept     = i_valid && o_in_ready;
  assign row_done   = accept && (row == 3'(BLK - 1));
  assign rd_addr    = ZZ[load_k];

  generate
    for (genvar b = 0; b < 2; b++) begin : g_bank
      zz_bank #(.DATA_W(DATA_W)) u_bank (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .wr_en    (accept && (wr_bank == 1'(b))),
        .wr_row   (row),
        .wr_data  (row_data),
        .rd_addr  (rd_addr),
        .rd_data  (bank_q[b]),
        .set_full (row_done && (wr_bank == 1'(b))),
        .clr_full (clr_rd && (rd_bank == 1'(b))),
        .full     (full[b])
      );
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      row     <= 3'd0;
      wr_bank <= 1'b0;
    end else if (accept) begin
      row <= row + 3'd1;
      if (row_done) begin
        wr_bank <= ~wr_bank;
      end
    end
  end

  // The output register is preloaded one step ahead, so the bank is read at ZZ[next k].
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    load_bank = rd_bank;
    load_k    = 6'd0;
    go_idle   = 1'b0;
    clr_rd    = 1'b0;
    case (state)
      IDLE: begin
        if (full[rd_bank]) begin
          load      = 1'b1;
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        if (o_valid && i_ready) begin
          if (o_index == 6'd63) begin
            clr_rd = 1'b1;
            if (full[~rd_bank]) begin
              load      = 1'b1;
              load_bank = ~rd_bank;
            end else begin
              go_idle   = 1'b1;
              state_nxt = IDLE;
            end
          end else begin
            load   = 1'b1;
            load_k = o_index + 6'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      rd_bank <= 1'b0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_index <= 6'd0;
      o_last  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (clr_rd) begin
        rd_bank <= ~rd_bank;
      end
      if (load) begin
        o_valid <= 1'b1;
        o_data  <= bank_q[load_bank];
        o_index <= load_k;
        o_last  <= (load_k == 6'd63);
      end else if (go_idle) begin
        o_valid <= 1'b0;
        o_index <= 6'd0;
        o_last  <= 1'b0;
      end
    end
  end

`ifdef DCT_ZZ_OVERFLOW_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_overflow <= 1'b0;
    end else if (i_valid && !o_in_ready) begin
      o_overflow <= 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_dct_zigzag_serializer.sv
// tb_dct_zigzag_serializer: directed self-checking bench for the zigzag serializer.
`default_nettype none

module tb_dct_zigzag_serializer;

  localparam int DW = 12;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_valid = 1'b0;
  logic          i_ready = 1'b1;
  logic [DW-1:0] d [8];
  logic          o_in_ready;
  logic [DW-1:0] o_data;
  logic          o_valid;
  logic [5:0]    o_index;
  logic          o_last;
`ifdef DCT_ZZ_OVERFLOW_EN
  logic          o_overflow;
`endif

  int checks   = 0;
  int failures = 0;

  int zz [64] = '{
    0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
   12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
   35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
   58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  dct_zigzag_serializer dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_valid    (i_valid),
    .i_data0    (d[0]),
    .i_data1    (d[1]),
    .i_data2    (d[2]),
    .i_data3    (d[3]),
    .i_data4    (d[4]),
    .i_data5    (d[5]),
    .i_data6    (d[6]),
    .i_data7    (d[7]),
    .o_in_ready (o_in_ready),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_index    (o_index),
    .o_last     (o_last)
`ifdef DCT_ZZ_OVERFLOW_EN
    ,
    .o_overflow (o_overflow)
`endif
  );

  always #5 i_clk = ~i_clk;

  // Raster position pos carries base+pos, except a few extreme values when ext is set.
  function automatic logic [DW-1:0] lane_val(input int base, input int pos, input bit ext);
    if (ext) begin
      if (pos == 0 || pos == 56) return 12'h800;
      if (pos == 63 || pos == 5) return 12'h7FF;
    end
    return DW'(base + pos);
  endfunction

  task automatic drive_row(input int r, input int base, input bit ext);
    for (int c = 0; c < 8; c++) d[c] = lane_val(base, r*8 + c, ext);
    i_valid = 1'b1;
  endtask

  // Ends at the negedge just after row 7 was accepted, with i_valid low.
  task automatic write_block(input int base, input bit ext, input bit gaps);
    for (int r = 0; r < 8; r++) begin
      @(negedge i_clk);
      drive_row(r, base, ext);
      if (gaps && r < 7) begin
        repeat ((r % 3) + 1) begin
          @(negedge i_clk);
          i_valid = 1'b0;
        end
      end
    end
    @(negedge i_clk);
    i_valid = 1'b0;
  endtask

  // Expects o_valid on every sampled cycle until all 64 coefficients are taken.
  task automatic read_block(input int base, input bit ext, input bit toggle, input string tag);
    int i = 0;
    int guard = 0;
    bit rdy = 1'b1;
    logic [DW-1:0] exp;
    while (i < 64 && guard < 300) begin
      @(negedge i_clk);
      guard++;
      rdy = toggle ? !rdy : 1'b1;
      i_ready = rdy;
      exp = lane_val(base, zz[i], ext);
      checks++;
      if (o_valid !== 1'b1 || o_data !== exp || o_index !== 6'(i) || o_last !== (i == 63)) begin
        failures++;
        $display("FAIL %s i=%0d valid=%b data=%h exp=%h index=%0d last=%b", tag, i,
                 o_valid, o_data, exp, o_index, o_last);
      end
      if (o_valid === 1'b1 && rdy) i++;
    end
    if (i < 64) begin
      checks++;
      failures++;
      $display("FAIL %s timeout got=%0d need=64", tag, i);
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int c = 0; c < 8; c++) d[c] = '0;
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
    checks++; if (o_data !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", o_data); end
    checks++; if (o_index !== 6'd0) begin failures++; $display("FAIL reset_index got=%0d exp=0", o_index); end
    checks++; if (o_last !== 1'b0) begin failures++; $display("FAIL reset_last got=%b exp=0", o_last); end
    checks++; if (o_in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", o_in_ready); end
`ifdef DCT_ZZ_OVERFLOW_EN
    checks++; if (o_overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", o_overflow); end
`endif
  endtask

  task automatic run_block(input int base, input bit ext, input bit toggle, input bit gaps,
                           input string tag);
    i_ready = 1'b1;
    write_block(base, ext, gaps);
    checks++;
    if (o_valid !== 1'b0) begin failures++; $display("FAIL %s_latency valid=%b exp=0", tag, o_valid); end
    read_block(base, ext, toggle, tag);
    @(negedge i_clk);
    checks++;
    if (o_valid !== 1'b0) begin failures++; $display("FAIL %s_drop valid=%b exp=0", tag, o_valid); end
    checks++;
    if (o_in_ready !== 1'b1) begin failures++; $display("FAIL %s_ready got=%b exp=1", tag, o_in_ready); end
  endtask

  task automatic test_single();   run_block(0, 1'b0, 1'b0, 1'b0, "single");  endtask
  task automatic test_stall();    run_block(0, 1'b0, 1'b1, 1'b0, "stall");   endtask
  task automatic test_gaps();     run_block(0, 1'b0, 1'b0, 1'b1, "gaps");    endtask
  task automatic test_extremes(); run_block(0, 1'b1, 1'b0, 1'b0, "extreme"); endtask

  task automatic test_back_to_back();
    i_ready = 1'b1;
    fork
      begin
        for (int j = 0; j < 24; j++) begin
          @(negedge i_clk);
          checks++;
          if (o_in_ready !== (j < 16)) begin
            failures++;
            $display("FAIL b2b_in_ready beat=%0d got=%b exp=%b", j, o_in_ready, (j < 16));
          end
          drive_row(j % 8, (j / 8) * 64, 1'b0);
        end
        @(negedge i_clk);
        i_valid = 1'b0;
        repeat (48) @(negedge i_clk);
        checks++;
        if (o_in_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_before got=%b exp=0", o_in_ready); end
        @(negedge i_clk);
        checks++;
        if (o_in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_after got=%b exp=1", o_in_ready); end
      end
      begin
        repeat (9) @(negedge i_clk);
        read_block(0, 1'b0, 1'b0, "b2b_blk0");
        read_block(64, 1'b0, 1'b0, "b2b_blk1");
      end
    join
    @(negedge i_clk);
    checks++;
    if (o_valid !== 1'b0) begin failures++; $display("FAIL b2b_end_valid got=%b exp=0", o_valid); end
`ifdef DCT_ZZ_OVERFLOW_EN
    checks++;
    if (o_overflow !== 1'b1) begin failures++; $display("FAIL b2b_overflow got=%b exp=1", o_overflow); end
`endif
  endtask

  task automatic test_mid_reset();
    int guard = 0;
    bit seen = 1'b0;
    i_ready = 1'b1;
    write_block(256, 1'b0, 1'b0);
    while (!seen && guard < 100) begin
      @(negedge i_clk);
      guard++;
      if (o_valid === 1'b1 && o_index === 6'd20) seen = 1'b1;
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL midrst_reach got=0 exp=1"); end
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", o_valid); end
    checks++; if (o_in_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b exp=1", o_in_ready); end
    checks++; if (o_index !== 6'd0) begin failures++; $display("FAIL midrst_index got=%0d exp=0", o_index); end
    checks++; if (o_data !== '0) begin failures++; $display("FAIL midrst_data got=%h exp=0", o_data); end
`ifdef DCT_ZZ_OVERFLOW_EN
    checks++; if (o_overflow !== 1'b0) begin failures++; $display("FAIL midrst_overflow got=%b exp=0", o_overflow); end
`endif
    repeat (3) begin
      @(negedge i_clk);
      checks++;
      if (o_valid !== 1'b0) begin failures++; $display("FAIL midrst_quiet got=%b exp=0", o_valid); end
    end
    run_block(512, 1'b0, 1'b0, 1'b0, "midrst_fresh");
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_gaps();
    test_extremes();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
